// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer
// Frame-level controller for the streaming convolution engine. On start it
// reads one IMG_W x IMG_H frame from the source memory in raster order and
// feeds it to the engine, captures the engine's output stream into the
// result memory at consecutive addresses, and then reports done/error.
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i, pause_i         frame start (IDLE only), read suspend (FEED only)
//   busy_o, done_o, err_o    status: active frame, end-of-frame pulse, sticky error
//   rd_en_o/rd_addr_o/rd_data_i       source memory read port (1-cycle latency)
//   conv_valid_o/conv_pixel_o         engine input stream
//   conv_valid_i/conv_pixel_i         engine output stream
//   wr_en_o/wr_addr_o/wr_data_o       result memory write port
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for start_i, all strobes low
// S_FEED  | issuing source reads, one per unpaused cycle
// S_DRAIN | all reads issued, waiting for remaining engine outputs
// S_DONE  | one-cycle done_o pulse, then back to S_IDLE
module conv_frame_sequencer #(
    parameter int IMG_W         = 480,
    parameter int IMG_H         = 480,
    parameter int OUT_PIXELS    = 228484,
    parameter int ADDR_W        = 18,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              pause_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [7:0]        rd_data_i,
    output logic              conv_valid_o,
    output logic [7:0]        conv_pixel_o,
    input  logic              conv_valid_i,
    input  logic [7:0]        conv_pixel_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [7:0]        wr_data_o
);

    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_RD  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [ADDR_W-1:0] OUT_CNT  = ADDR_W'(OUT_PIXELS);
    localparam logic [ADDR_W-1:0] OUT_LAST = ADDR_W'(OUT_PIXELS - 1);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(DRAIN_TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] rd_cnt;
    logic [ADDR_W-1:0] wr_cnt;
    logic [TMR_W-1:0]  idle_tmr;
    logic              err;
    logic              conv_valid;
    logic              active;
    logic              capture;
    logic              overflow;
    logic              start_ok;
    logic              timeout;

    assign active   = (state == S_FEED) || (state == S_DRAIN);
    assign capture  = active && conv_valid_i && (wr_cnt < OUT_CNT);
    assign overflow = active && conv_valid_i && (wr_cnt == OUT_CNT);

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        rd_en_o    = 1'b0;
        start_ok   = 1'b0;
        timeout    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    start_ok   = 1'b1;
                    state_next = S_FEED;
                end
            end
            S_FEED: begin
                busy_o  = 1'b1;
                rd_en_o = !pause_i;
                if (!pause_i && (rd_cnt == LAST_RD)) begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                // Leave in the same cycle as the final write so done_o follows it directly.
                if ((wr_cnt == OUT_CNT) || (capture && (wr_cnt == OUT_LAST))) begin
                    state_next = S_DONE;
                end else if (!conv_valid_i && (idle_tmr == TMR_W'(1))) begin
                    timeout    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                done_o     = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            rd_cnt     <= '0;
            wr_cnt     <= '0;
            idle_tmr   <= TMR_LOAD;
            err        <= 1'b0;
            conv_valid <= 1'b0;
        end else begin
            state      <= state_next;
            conv_valid <= rd_en_o;
            if (start_ok) begin
                rd_cnt <= '0;
                wr_cnt <= '0;
                err    <= 1'b0;
            end else begin
                // Hold on the last address so the counter never wraps.
                if (rd_en_o && (rd_cnt != LAST_RD)) begin
                    rd_cnt <= rd_cnt + ADDR_W'(1);
                end
                if (capture) begin
                    wr_cnt <= wr_cnt + ADDR_W'(1);
                end
                if (overflow || timeout) begin
                    err <= 1'b1;
                end
            end
            // Counts consecutive idle DRAIN cycles; reloaded outside DRAIN and on every output.
            if ((state != S_DRAIN) || conv_valid_i) begin
                idle_tmr <= TMR_LOAD;
            end else begin
                idle_tmr <= idle_tmr - TMR_W'(1);
            end
        end
    end

    assign rd_addr_o    = rd_cnt;
    assign err_o        = err;
    assign conv_valid_o = conv_valid;
    assign conv_pixel_o = conv_valid ? rd_data_i : 8'd0;
    assign wr_en_o      = capture;
    assign wr_addr_o    = capture ? wr_cnt : '0;
    assign wr_data_o    = capture ? conv_pixel_i : 8'd0;

endmodule

// File: tb/tb_conv_frame_sequencer.sv
module tb_conv_frame_sequencer;

    localparam int IMG_W         = 4;
    localparam int IMG_H         = 4;
    localparam int NPIX          = IMG_W * IMG_H;
    localparam int OUT_PIXELS    = 4;
    localparam int ADDR_W        = 4;
    localparam int DRAIN_TIMEOUT = 8;
    localparam int PRE           = 3;
    localparam int MAXC          = 128;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic              pause_i;
    logic              busy_o;
    logic              done_o;
    logic              err_o;
    logic              rd_en_o;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [7:0]        rd_data_i;
    logic              conv_valid_o;
    logic [7:0]        conv_pixel_o;
    logic              conv_valid_i;
    logic [7:0]        conv_pixel_i;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [7:0]        wr_data_o;

    always #5 clk = ~clk;

    conv_frame_sequencer #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .OUT_PIXELS(OUT_PIXELS),
        .ADDR_W(ADDR_W), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
    ) u_dut (
        .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .pause_i(pause_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .rd_en_o(rd_en_o), .rd_addr_o(rd_addr_o), .rd_data_i(rd_data_i),
        .conv_valid_o(conv_valid_o), .conv_pixel_o(conv_pixel_o),
        .conv_valid_i(conv_valid_i), .conv_pixel_i(conv_pixel_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o)
    );

    int    checks;
    int    failures;
    string frame;

    logic [7:0] src [NPIX];
    bit         err_model;
    bit         prev_rd;
    int         prev_addr;

    // Per-cycle plan, cycle 0 = the IDLE cycle in which start_i is presented.
    bit         pz     [MAXC];
    bit         st     [MAXC];
    bit         ov     [MAXC];
    logic [7:0] od     [MAXC];
    bit         e_rd   [MAXC];
    int         e_ra   [MAXC];
    bit         e_cv   [MAXC];
    logic [7:0] e_px   [MAXC];
    bit         e_wr   [MAXC];
    int         e_wa   [MAXC];
    logic [7:0] e_wd   [MAXC];
    bit         e_busy [MAXC];
    bit         e_err  [MAXC];
    int         read_cyc [NPIX];
    int         done_c;
    int         last_out;

    task automatic chk(input string tag, input int c, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s/%s c=%0d observed=%0d expected=%0d", frame, tag, c, obs, exp);
        end
    endtask

    task automatic check_reset(input int c);
        chk("rst_busy", c, int'(busy_o), 0);
        chk("rst_done", c, int'(done_o), 0);
        chk("rst_err", c, int'(err_o), 0);
        chk("rst_rd_en", c, int'(rd_en_o), 0);
        chk("rst_rd_addr", c, int'(rd_addr_o), 0);
        chk("rst_conv_valid", c, int'(conv_valid_o), 0);
        chk("rst_conv_pixel", c, int'(conv_pixel_o), 0);
        chk("rst_wr_en", c, int'(wr_en_o), 0);
        chk("rst_wr_addr", c, int'(wr_addr_o), 0);
        chk("rst_wr_data", c, int'(wr_data_o), 0);
    endtask

    // Source memory answers the previous cycle's read; otherwise the bus carries junk.
    task automatic drive_cycle(input bit s, input bit p, input bit v, input logic [7:0] px, input bit r);
        start_i      = s;
        pause_i      = p;
        conv_valid_i = v;
        conv_pixel_i = px;
        rst_i        = r;
        rd_data_i    = prev_rd ? src[prev_addr] : 8'($urandom);
        #1;
    endtask

    task automatic end_cycle();
        prev_rd   = rd_en_o;
        prev_addr = int'(rd_addr_o);
        @(posedge clk);
        #1;
    endtask

    // Reference timeline: reads one per unpaused cycle after start, engine echoes
    // the selected input pixels 'lat' cycles after it sees them, results fill
    // addresses 0.. in order, frame ends when all expected outputs are stored or
    // DRAIN_TIMEOUT consecutive output-free cycles pass after the last read.
    task automatic plan_frame(input int lat, input logic [NPIX-1:0] emit);
        int k;
        int wcnt;
        int idle;
        int last_rd;
        int oc;
        bit errf;
        k        = 0;
        last_out = 0;
        for (int c = 1; c < MAXC && k < NPIX; c++) begin
            if (!pz[c]) begin
                read_cyc[k] = c;
                e_rd[c]     = 1'b1;
                e_ra[c]     = k;
                k++;
            end
        end
        last_rd = read_cyc[NPIX-1];
        for (int i = 0; i < NPIX; i++) begin
            e_cv[read_cyc[i] + 1] = 1'b1;
            e_px[read_cyc[i] + 1] = src[i];
            if (emit[i]) begin
                oc     = read_cyc[i] + 1 + lat;
                ov[oc] = 1'b1;
                od[oc] = src[i];
                if (oc > last_out) last_out = oc;
            end
        end
        wcnt     = 0;
        idle     = 0;
        errf     = 1'b0;
        done_c   = MAXC - 2;
        e_err[0] = err_model;
        for (int c = 1; c < MAXC - 2; c++) begin
            e_err[c]  = errf;
            e_busy[c] = 1'b1;
            if (ov[c]) begin
                if (wcnt < OUT_PIXELS) begin
                    e_wr[c] = 1'b1;
                    e_wa[c] = wcnt;
                    e_wd[c] = od[c];
                    wcnt++;
                end else begin
                    errf = 1'b1;
                end
            end
            if (c > last_rd) begin
                if (wcnt == OUT_PIXELS) begin
                    done_c = c + 1;
                    break;
                end
                idle = ov[c] ? 0 : idle + 1;
                if (idle == DRAIN_TIMEOUT) begin
                    errf   = 1'b1;
                    done_c = c + 1;
                    break;
                end
            end
        end
        for (int c = done_c; c < MAXC; c++) begin
            e_err[c]  = errf;
            e_busy[c] = 1'b0;
        end
        err_model = errf;
    endtask

    task automatic do_frame(input string name, input int lat, input logic [NPIX-1:0] emit,
                            input int pause_from, input int pause_len, input bit rand_pause,
                            input bit rand_start, input bit hold, input bit rst_mid);
        int rst_at;
        int c_end;
        frame = name;
        for (int p = 0; p < PRE; p++) begin
            drive_cycle(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0);
            chk("idle_busy", -p, int'(busy_o), 0);
            chk("idle_done", -p, int'(done_o), 0);
            chk("idle_rd_en", -p, int'(rd_en_o), 0);
            chk("idle_wr_en", -p, int'(wr_en_o), 0);
            chk("idle_conv_pixel", -p, int'(conv_pixel_o), 0);
            chk("idle_err", -p, int'(err_o), int'(err_model));
            end_cycle();
        end
        for (int c = 0; c < MAXC; c++) begin
            pz[c] = 0; st[c] = 0; ov[c] = 0; od[c] = 0; e_rd[c] = 0; e_ra[c] = 0;
            e_cv[c] = 0; e_px[c] = 0; e_wr[c] = 0; e_wa[c] = 0; e_wd[c] = 0;
            e_busy[c] = 0; e_err[c] = 0;
        end
        for (int c = pause_from; c < pause_from + pause_len; c++) pz[c] = 1'b1;
        if (rand_pause) begin
            for (int c = 1; c < 50; c++) pz[c] = ($urandom_range(3) == 0);
        end
        plan_frame(lat, emit);
        rst_at = rst_mid ? read_cyc[9] : -1;
        st[0]  = 1'b1;
        if (hold) begin
            for (int c = 0; c <= done_c + 1; c++) st[c] = 1'b1;
        end
        if (rand_start) begin
            for (int c = 1; c <= done_c; c++) st[c] = 1'($urandom);
        end
        if (hold)         c_end = done_c + 1;
        else if (rst_mid) c_end = rst_at + 1;
        else              c_end = (last_out > done_c + 1) ? last_out : done_c + 1;

        for (int c = 0; c <= c_end; c++) begin
            drive_cycle(st[c], pz[c], ov[c], ov[c] ? od[c] : 8'($urandom), c == rst_at);
            if (rst_mid && c == rst_at + 1) begin
                check_reset(c);
            end else begin
                chk("busy", c, int'(busy_o), int'(e_busy[c]));
                chk("done", c, int'(done_o), int'(c == done_c));
                chk("err", c, int'(err_o), int'(e_err[c]));
                chk("rd_en", c, int'(rd_en_o), int'(e_rd[c]));
                if (e_rd[c]) chk("rd_addr", c, int'(rd_addr_o), e_ra[c]);
                chk("conv_valid", c, int'(conv_valid_o), int'(e_cv[c]));
                chk("conv_pixel", c, int'(conv_pixel_o), e_cv[c] ? int'(e_px[c]) : 0);
                chk("wr_en", c, int'(wr_en_o), int'(e_wr[c]));
                if (e_wr[c]) begin
                    chk("wr_addr", c, int'(wr_addr_o), e_wa[c]);
                    chk("wr_data", c, int'(wr_data_o), int'(e_wd[c]));
                end
            end
            end_cycle();
        end
        if (rst_mid) err_model = 1'b0;
        if (hold) begin
            drive_cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
            chk("restart_busy", c_end + 1, int'(busy_o), 1);
            chk("restart_rd_en", c_end + 1, int'(rd_en_o), 1);
            chk("restart_rd_addr", c_end + 1, int'(rd_addr_o), 0);
            end_cycle();
            drive_cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
            end_cycle();
            err_model = 1'b0;
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        err_model    = 1'b0;
        prev_rd      = 1'b0;
        prev_addr    = 0;
        rst_i        = 1'b1;
        start_i      = 1'b0;
        pause_i      = 1'b0;
        conv_valid_i = 1'b0;
        conv_pixel_i = 8'd0;
        rd_data_i    = 8'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        frame = "reset";
        check_reset(0);
        rst_i = 1'b0;

        for (int i = 0; i < NPIX; i++) src[i] = 8'(20 + i);
        do_frame("basic",    3, 16'h0660, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame("pause",    3, 16'h0660, 8, 3, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame("timeout",  3, 16'h0260, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame("overflow", 3, 16'h0E60, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame("rst_mid",  3, 16'h0660, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_frame("clean",    3, 16'h0660, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_frame("hold",     3, 16'h0660, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < NPIX; i++) src[i] = 8'($urandom);
            do_frame($sformatf("rand%0d", r), 1 + $urandom_range(5),
                     16'($urandom) & 16'($urandom), 0, 0, 1'b1, 1'b1, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
